// File: rtl/tile_scheduler.sv
// Multi-tile sequencer for the CNN core: per tile, clear registers, stream host
// weights into the weight SPAD, fire a routing run and wait for core completion.
module tile_scheduler #(
    parameter int               ADDR_WIDTH      = 8,
    parameter int               SRAM_DATA_WIDTH = 64,
    parameter int               TILE_WIDTH      = 4,
    parameter int               CNT_WIDTH       = 16,
    parameter int               TIMEOUT         = 4096,
    parameter logic [1:0]       WEIGHT_SRAM     = 2'd0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic [TILE_WIDTH-1:0]      i_num_tiles,
    input  logic [ADDR_WIDTH-1:0]      i_w_words,
    input  logic [SRAM_DATA_WIDTH-1:0] i_w_data,
    input  logic                       i_w_valid,
    output logic                       o_w_ready,
    output logic [SRAM_DATA_WIDTH-1:0] o_data_in,
    output logic [ADDR_WIDTH-1:0]      o_write_addr,
    output logic [1:0]                 o_spad_select,
    output logic                       o_write_en,
    output logic                       o_reg_clear,
    output logic                       o_route_en,
    input  logic                       i_core_done,
    input  logic                       i_ofmap_valid,
    output logic                       o_busy,
    output logic [TILE_WIDTH-1:0]      o_tile_idx,
    output logic [CNT_WIDTH-1:0]       o_ofmap_count,
    output logic                       o_done,
    output logic                       o_error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_ROUTE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [2:0]            state, state_nx;
    logic [TILE_WIDTH-1:0] num_tiles_q;
    logic [ADDR_WIDTH-1:0] w_words_q;
    logic [ADDR_WIDTH-1:0] wcnt;
    logic [WD_W-1:0]       wd;
    logic                  hs, last_tile, core_ack, wd_expire, last_word;

    assign o_w_ready     = (state == S_LOAD);
    assign o_busy        = (state != S_IDLE);
    assign o_spad_select = WEIGHT_SRAM;

    assign hs        = i_w_valid && o_w_ready;
    assign last_word = (wcnt == w_words_q - ADDR_WIDTH'(1));
    assign last_tile = (o_tile_idx == num_tiles_q - TILE_WIDTH'(1));
    // wd==0 marks the first WAIT cycle, where a leftover done level is ignored
    assign core_ack  = i_core_done && (wd != '0);
    assign wd_expire = (wd == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (i_start) state_nx = (i_num_tiles == '0) ? S_DONE : S_CLEAR;
            S_CLEAR: state_nx = (w_words_q == '0) ? S_ROUTE : S_LOAD;
            S_LOAD:  if (hs && last_word) state_nx = S_ROUTE;
            S_ROUTE: state_nx = S_WAIT;
            S_WAIT: begin
                if (core_ack)       state_nx = last_tile ? S_DONE : S_CLEAR;
                else if (wd_expire) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (i_abort) state_nx = S_IDLE;
    end

    // Core-side pulses are registered decodes of the current state, so an abort
    // in the same cycle cancels them before they ever leave the block.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_IDLE;
            o_write_en   <= 1'b0;
            o_reg_clear  <= 1'b0;
            o_route_en   <= 1'b0;
            o_done       <= 1'b0;
            o_write_addr <= '0;
            o_data_in    <= '0;
            wcnt         <= '0;
            wd           <= '0;
        end else begin
            state       <= state_nx;
            o_write_en  <= hs && !i_abort;
            o_reg_clear <= (state == S_CLEAR) && !i_abort;
            o_route_en  <= (state == S_ROUTE) && !i_abort;
            o_done      <= (state == S_DONE) && !i_abort;
            if (hs) begin
                o_write_addr <= wcnt;
                o_data_in    <= i_w_data;
                wcnt         <= wcnt + ADDR_WIDTH'(1);
            end
            if (state == S_CLEAR) wcnt <= '0;
            if (state == S_ROUTE)
                wd <= '0;
            else if (state == S_WAIT && !wd_expire)
                wd <= wd + WD_W'(1);
        end
    end

    // Run bookkeeping; held across an abort so the host can inspect it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            num_tiles_q   <= '0;
            w_words_q     <= '0;
            o_tile_idx    <= '0;
            o_ofmap_count <= '0;
            o_error       <= 1'b0;
        end else if (!i_abort) begin
            if (state == S_IDLE && i_start) begin
                num_tiles_q   <= i_num_tiles;
                w_words_q     <= i_w_words;
                o_tile_idx    <= '0;
                o_ofmap_count <= '0;
                o_error       <= 1'b0;
            end
            if (state == S_WAIT && core_ack && !last_tile)
                o_tile_idx <= o_tile_idx + TILE_WIDTH'(1);
            if (state == S_WAIT && !core_ack && wd_expire)
                o_error <= 1'b1;
            if (state != S_IDLE && i_ofmap_valid && o_ofmap_count != '1)
                o_ofmap_count <= o_ofmap_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_tile_scheduler.sv
// Randomized bench for tile_scheduler: a host word feeder, a core responder and a
// negedge monitor collect transactions that each test compares with its own model.
module tb_tile_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [3:0]  num_tiles = '0;
    logic [7:0]  w_words = '0;
    logic [63:0] w_data = '0;
    logic        w_valid = 1'b0;
    logic        core_done = 1'b0, ofmap_valid = 1'b0;
    logic        o_w_ready, o_write_en, o_reg_clear, o_route_en, o_busy, o_done, o_error;
    logic [63:0] o_data_in;
    logic [7:0]  o_write_addr;
    logic [1:0]  o_spad_select;
    logic [3:0]  o_tile_idx;
    logic [15:0] o_ofmap_count;

    tile_scheduler #(.ADDR_WIDTH(8), .SRAM_DATA_WIDTH(64), .TILE_WIDTH(4), .CNT_WIDTH(16),
                     .TIMEOUT(16), .WEIGHT_SRAM(2'd0)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_num_tiles(num_tiles), .i_w_words(w_words), .i_w_data(w_data), .i_w_valid(w_valid),
        .o_w_ready(o_w_ready), .o_data_in(o_data_in), .o_write_addr(o_write_addr),
        .o_spad_select(o_spad_select), .o_write_en(o_write_en), .o_reg_clear(o_reg_clear),
        .o_route_en(o_route_en), .i_core_done(core_done), .i_ofmap_valid(ofmap_valid),
        .o_busy(o_busy), .o_tile_idx(o_tile_idx), .o_ofmap_count(o_ofmap_count),
        .o_done(o_done), .o_error(o_error));

    always #5 clk = ~clk;

    logic [100:0] all_out;
    assign all_out = {o_w_ready, o_data_in, o_write_addr, o_spad_select, o_write_en, o_reg_clear,
                      o_route_en, o_busy, o_tile_idx, o_ofmap_count, o_done, o_error};

    int n_tests = 0, n_fail = 0;

    // ---------------- host word feeder ----------------
    logic [63:0] host_q[$];
    int          gap_pct = 30;
    initial begin : host
        bit took;
        forever begin
            @(negedge clk);
            took = w_valid && o_w_ready;
            @(posedge clk); #1;
            if (took && host_q.size() > 0) void'(host_q.pop_front());
            if (host_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                w_valid = 1'b1;
                w_data  = host_q[0];
            end else begin
                w_valid = 1'b0;
            end
        end
    end

    // ---------------- core responder ----------------
    int beats_q[$], cgap_q[$];
    bit stale_q[$];
    bit core_hang = 1'b0;
    initial begin : core
        int nb, gp;
        bit st;
        forever begin
            @(negedge clk);
            if (o_route_en && !core_hang) begin
                nb = (beats_q.size() > 0) ? beats_q.pop_front() : 0;
                gp = (cgap_q.size() > 0) ? cgap_q.pop_front() : 1;
                st = (stale_q.size() > 0) ? stale_q.pop_front() : 1'b0;
                core_done = st;
                @(posedge clk); #1 core_done = 1'b0;
                repeat (nb) begin ofmap_valid = 1'b1; @(posedge clk); #1; end
                ofmap_valid = 1'b0;
                repeat (gp) begin @(posedge clk); #1; end
                core_done = 1'b1;
                @(posedge clk); #1 core_done = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    int          cyc = 0, clr_n, route_n, done_n, route_cyc, done_cyc;
    bit          ready_seen, done_err;
    logic [15:0] done_cnt;
    logic [7:0]  wr_addr_q[$];
    logic [63:0] wr_data_q[$];
    logic [3:0]  route_tile_q[$];
    always @(negedge clk) begin
        cyc++;
        if (o_write_en) begin wr_addr_q.push_back(o_write_addr); wr_data_q.push_back(o_data_in); end
        if (o_reg_clear) clr_n++;
        if (o_route_en) begin route_n++; route_cyc = cyc; route_tile_q.push_back(o_tile_idx); end
        if (o_w_ready) ready_seen = 1'b1;
        if (o_done) begin done_n++; done_cyc = cyc; done_err = o_error; done_cnt = o_ofmap_count; end
    end

    task automatic clear_mon();
        clr_n = 0; route_n = 0; done_n = 0; route_cyc = 0; done_cyc = 0;
        ready_seen = 1'b0; done_err = 1'b0; done_cnt = '0;
        wr_addr_q.delete(); wr_data_q.delete(); route_tile_q.delete();
    endtask

    task automatic pulse_start(input int tiles, input int words);
        @(posedge clk); #1;
        num_tiles = 4'(tiles); w_words = 8'(words); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        for (int c = 0; c < 3000 && done_n == 0; c++) begin @(negedge clk); #1; end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_tests++; if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    endtask

    task automatic test_single();
        logic [63:0] exp_d[$];
        clear_mon(); gap_pct = 40;
        for (int i = 0; i < 3; i++) begin exp_d.push_back({$urandom, $urandom}); host_q.push_back(exp_d[i]); end
        beats_q.push_back(0); cgap_q.push_back(9); stale_q.push_back(1'b0);
        pulse_start(1, 3);
        wait_done();
        n_tests++; if (wr_addr_q.size() != 3) begin n_fail++; $display("FAIL single_nwrites: got %0d want 3", wr_addr_q.size()); end
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            n_tests++; if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== exp_d[i]) begin
                n_fail++; $display("FAIL single_write%0d: got %0h/%h want %0h/%h", i, wr_addr_q[i], wr_data_q[i], i, exp_d[i]); end
        end
        n_tests++; if (clr_n != 1 || route_n != 1 || done_n != 1) begin
            n_fail++; $display("FAIL single_pulses: clr %0d route %0d done %0d want 1/1/1", clr_n, route_n, done_n); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_multi();
        clear_mon(); gap_pct = 20;
        for (int i = 0; i < 6; i++) host_q.push_back({$urandom, $urandom});
        for (int t = 0; t < 3; t++) begin beats_q.push_back(4); cgap_q.push_back(2); stale_q.push_back(1'b1); end
        pulse_start(3, 2);
        wait_done();
        n_tests++; if (clr_n != 3 || route_n != 3) begin n_fail++; $display("FAIL multi_pulses: clr %0d route %0d want 3/3", clr_n, route_n); end
        for (int t = 0; t < 3 && t < route_tile_q.size(); t++) begin
            n_tests++; if (route_tile_q[t] !== 4'(t)) begin n_fail++; $display("FAIL multi_tile%0d: got %0d want %0d", t, route_tile_q[t], t); end
        end
        n_tests++; if (done_n != 1 || done_cnt !== 16'd12) begin n_fail++; $display("FAIL multi_ofmap: done %0d count %0d want 1/12", done_n, done_cnt); end
    endtask

    task automatic test_zero_words();
        clear_mon();
        for (int t = 0; t < 2; t++) begin beats_q.push_back(1); cgap_q.push_back(1); stale_q.push_back(1'b0); end
        pulse_start(2, 0);
        wait_done();
        n_tests++; if (wr_addr_q.size() != 0 || ready_seen) begin
            n_fail++; $display("FAIL zero_words_load: writes %0d ready_seen %b want 0/0", wr_addr_q.size(), ready_seen); end
        n_tests++; if (route_n != 2 || clr_n != 2 || done_n != 1) begin
            n_fail++; $display("FAIL zero_words_pulses: route %0d clr %0d done %0d want 2/2/1", route_n, clr_n, done_n); end
    endtask

    task automatic test_zero_tiles();
        clear_mon();
        @(posedge clk); #1; num_tiles = '0; w_words = 8'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        n_tests++; if (o_done !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL zero_tiles_c1: done %b busy %b want 0/1", o_done, o_busy); end
        @(negedge clk);
        n_tests++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL zero_tiles_c2: done %b want 1", o_done); end
        repeat (4) @(negedge clk);
        n_tests++; if (clr_n != 0 || route_n != 0 || wr_addr_q.size() != 0 || done_n != 1) begin
            n_fail++; $display("FAIL zero_tiles_quiet: clr %0d route %0d wr %0d done %0d want 0/0/0/1", clr_n, route_n, wr_addr_q.size(), done_n); end
    endtask

    task automatic test_timeout();
        clear_mon(); core_hang = 1'b1;
        host_q.push_back({$urandom, $urandom});
        pulse_start(1, 1);
        wait_done();
        n_tests++; if (done_n != 1 || !done_err) begin n_fail++; $display("FAIL timeout_flag: done %0d err %b want 1/1", done_n, done_err); end
        n_tests++; if (done_cyc - route_cyc != 17) begin n_fail++; $display("FAIL timeout_len: got %0d want 17", done_cyc - route_cyc); end
        repeat (5) @(negedge clk);
        n_tests++; if (o_error !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", o_error); end
        core_hang = 1'b0;
    endtask

    task automatic test_abort();
        clear_mon(); gap_pct = 0;
        host_q.push_back({$urandom, $urandom});
        pulse_start(1, 4);
        for (int c = 0; c < 200 && wr_addr_q.size() == 0; c++) @(negedge clk);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        for (int i = 0; i < 3; i++) host_q.push_back({$urandom, $urandom});
        @(negedge clk);
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: busy %b want 0", o_busy); end
        repeat (10) @(negedge clk);
        n_tests++; if (wr_addr_q.size() != 1 || done_n != 0 || route_n != 0) begin
            n_fail++; $display("FAIL abort_quiet: wr %0d done %0d route %0d want 1/0/0", wr_addr_q.size(), done_n, route_n); end
        host_q.delete(); gap_pct = 30;
    endtask

    task automatic test_rst_wait();
        clear_mon(); core_hang = 1'b1;
        pulse_start(1, 0);
        for (int c = 0; c < 200 && route_n == 0; c++) @(negedge clk);
        @(posedge clk); #1;
        repeat (3) begin ofmap_valid = 1'b1; @(posedge clk); #1; end
        ofmap_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (o_ofmap_count !== 16'd3 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: count %0d busy %b want 3/1", o_ofmap_count, o_busy); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (all_out !== '0) begin n_fail++; $display("FAIL rst_async: got %h want 0", all_out); end
        @(posedge clk); #1 rst = 1'b0;
        core_hang = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int tiles, words, bsum;
            logic [63:0] exp_d[$];
            tiles = $urandom_range(1, 4); words = $urandom_range(0, 5); bsum = 0;
            clear_mon(); gap_pct = $urandom_range(0, 50);
            for (int t = 0; t < tiles; t++) begin
                int b;
                b = $urandom_range(0, 4); bsum += b;
                beats_q.push_back(b); cgap_q.push_back($urandom_range(1, 5)); stale_q.push_back(1'($urandom));
                for (int w = 0; w < words; w++) begin exp_d.push_back({$urandom, $urandom}); host_q.push_back(exp_d[$]); end
            end
            pulse_start(tiles, words);
            wait_done();
            n_tests++; if (done_n != 1 || done_err || done_cnt !== 16'(bsum)) begin
                n_fail++; $display("FAIL rand%0d_done: done %0d err %b count %0d want 1/0/%0d", it, done_n, done_err, done_cnt, bsum); end
            n_tests++; if (clr_n != tiles || route_n != tiles || ready_seen != (words != 0)) begin
                n_fail++; $display("FAIL rand%0d_pulses: clr %0d route %0d ready %b want %0d/%0d/%b", it, clr_n, route_n, ready_seen, tiles, tiles, words != 0); end
            n_tests++; if (wr_addr_q.size() != exp_d.size()) begin
                n_fail++; $display("FAIL rand%0d_nwrites: got %0d want %0d", it, wr_addr_q.size(), exp_d.size()); end
            for (int i = 0; i < exp_d.size() && i < wr_addr_q.size(); i++) begin
                n_tests++; if (wr_addr_q[i] !== 8'(i % words) || wr_data_q[i] !== exp_d[i]) begin
                    n_fail++; $display("FAIL rand%0d_write%0d: got %0h/%h want %0h/%h", it, i, wr_addr_q[i], wr_data_q[i], i % words, exp_d[i]); end
            end
            for (int t = 0; t < route_tile_q.size(); t++) begin
                n_tests++; if (route_tile_q[t] !== 4'(t)) begin n_fail++; $display("FAIL rand%0d_tile%0d: got %0d want %0d", it, t, route_tile_q[t], t); end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_single();
        test_multi();
        test_zero_words();
        test_zero_tiles();
        test_timeout();
        test_random();
        test_abort();
        test_rst_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
